// File: rtl/painterengine_gpu_pattern_gen.sv
// Test-pattern generator: emits a frame as cache-sized horizontal bursts to the AXI burst writer.
// Optional PATTERN_GEN_FRAME_REPEAT_EN adds a frame counter and back-to-back frames while start is held.
`timescale 1ns/1ps
module painterengine_gpu_pattern_gen #(
  parameter int PARAM_ADDRESS_WIDTH  = 32,
  parameter int PARAM_CACHE_MAX_SIZE = 64,
  parameter int PARAM_CHECKER_SHIFT  = 3
) (
  input  logic                              i_wire_axi_clock,
  input  logic                              i_wire_resetn,
  input  logic                              i_wire_start,
  input  logic [1:0]                        i_wire_mode,
  input  logic [31:0]                       i_wire_color0,
  input  logic [31:0]                       i_wire_color1,
  input  logic [15:0]                       i_wire_display_width,
  input  logic [15:0]                       i_wire_display_height,
  input  logic [PARAM_ADDRESS_WIDTH-1:0]    i_wire_base_address,
  output logic [PARAM_ADDRESS_WIDTH-1:0]    o_wire_cache_address,
  output logic [8:0]                        o_wire_cache_length,
  output logic [32*PARAM_CACHE_MAX_SIZE-1:0] o_wire_cache,
  output logic                              o_wire_writer_enable,
  input  logic                              i_wire_writer_done,
  output logic                              o_wire_busy,
  output logic                              o_wire_done
`ifdef PATTERN_GEN_FRAME_REPEAT_EN
  ,
  output logic [15:0]                       o_wire_frame_count
`endif
);

  localparam int          CACHE_W   = 32 * PARAM_CACHE_MAX_SIZE;
  localparam logic [16:0] CACHE_LEN = 17'(PARAM_CACHE_MAX_SIZE);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_REQ, ST_DONE} state_t;

  state_t                         state_q, state_d;
  logic [1:0]                     mode_q, mode_d;
  logic [31:0]                    color0_q, color0_d;
  logic [31:0]                    color1_q, color1_d;
  logic [15:0]                    width_q, width_d;
  logic [15:0]                    height_q, height_d;
  logic [PARAM_ADDRESS_WIDTH-1:0] base_q, base_d;
  logic [15:0]                    x_q, x_d;
  logic [15:0]                    y_q, y_d;
  logic [CACHE_W-1:0]             cache_q, cache_d;
  logic [PARAM_ADDRESS_WIDTH-1:0] address_q, address_d;
  logic [8:0]                     length_q, length_d;
  logic                           enable_q, enable_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
`ifdef PATTERN_GEN_FRAME_REPEAT_EN
  logic [15:0]                    frame_count_q, frame_count_d;
`endif

  logic                           launch;
  logic [16:0]                    remain;
  logic [8:0]                     fill_len;
  logic [31:0]                    fill_offset;
  logic [PARAM_ADDRESS_WIDTH-1:0] fill_addr;
  logic [CACHE_W-1:0]             fill_cache;
  logic [16:0]                    x_adv;
  logic [16:0]                    y_adv;

  // Burst geometry for the current (x, y) position of the latched frame.
  assign remain      = {1'b0, width_q} - {1'b0, x_q};
  assign fill_len    = (remain > CACHE_LEN) ? CACHE_LEN[8:0] : remain[8:0];
  assign fill_offset = (({16'd0, y_q} * {16'd0, width_q}) + {16'd0, x_q}) << 2;
  assign fill_addr   = base_q + PARAM_ADDRESS_WIDTH'(fill_offset);

  assign x_adv = {1'b0, x_q} + {8'd0, length_q};
  assign y_adv = {1'b0, y_q} + 17'd1;

  generate
    for (genvar gi = 0; gi < PARAM_CACHE_MAX_SIZE; gi++) begin : g_pixel
      logic [15:0] px_x;
      logic        checker_bit;
      logic [31:0] px;

      assign px_x        = x_q + 16'(gi);
      assign checker_bit = |(((px_x >> PARAM_CHECKER_SHIFT) ^ (y_q >> PARAM_CHECKER_SHIFT)) & 16'd1);

      always_comb begin
        px = color0_q;
        case (mode_q)
          2'd0:    px = color0_q;
          2'd1:    px = checker_bit ? color1_q : color0_q;
          2'd2:    px = {8'hFF, px_x[7:0], px_x[7:0], px_x[7:0]};
          default: px = {8'hFF, y_q[7:0], y_q[7:0], y_q[7:0]};
        endcase
      end

      // Slots past the burst length are zeroed so the writer never sees stale pixels.
      assign fill_cache[gi*32 +: 32] = (9'(gi) < fill_len) ? px : 32'h0;
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    color0_d  = color0_q;
    color1_d  = color1_q;
    width_d   = width_q;
    height_d  = height_q;
    base_d    = base_q;
    x_d       = x_q;
    y_d       = y_q;
    cache_d   = cache_q;
    address_d = address_q;
    length_d  = length_q;
    done_d    = 1'b0;
    launch    = 1'b0;
`ifdef PATTERN_GEN_FRAME_REPEAT_EN
    frame_count_d = frame_count_q;
`endif

    case (state_q)
      ST_IDLE: launch = i_wire_start;
      ST_FILL: begin
        cache_d   = fill_cache;
        address_d = fill_addr;
        length_d  = fill_len;
        state_d   = ST_REQ;
      end
      ST_REQ: begin
        if (i_wire_writer_done) begin
          if (x_adv >= {1'b0, width_q}) begin
            x_d = 16'd0;
            y_d = y_adv[15:0];
            if (y_adv >= {1'b0, height_q}) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_FILL;
            end
          end else begin
            x_d     = x_adv[15:0];
            state_d = ST_FILL;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef PATTERN_GEN_FRAME_REPEAT_EN
        launch = i_wire_start;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame launch snapshots the configuration so later input changes cannot disturb the frame.
    if (launch) begin
      mode_d   = i_wire_mode;
      color0_d = i_wire_color0;
      color1_d = i_wire_color1;
      width_d  = i_wire_display_width;
      height_d = i_wire_display_height;
      base_d   = i_wire_base_address;
      x_d      = 16'd0;
      y_d      = 16'd0;
      if (i_wire_display_width == 16'd0 || i_wire_display_height == 16'd0) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_FILL;
      end
    end

`ifdef PATTERN_GEN_FRAME_REPEAT_EN
    if (done_d) frame_count_d = frame_count_q + 16'd1;
`endif

    // The request is a registered copy of the REQ state, so it trails the state by one cycle.
    enable_d = (state_q == ST_REQ);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_wire_axi_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_q   <= ST_IDLE;
      mode_q    <= 2'd0;
      color0_q  <= 32'h0;
      color1_q  <= 32'h0;
      width_q   <= 16'd0;
      height_q  <= 16'd0;
      base_q    <= '0;
      x_q       <= 16'd0;
      y_q       <= 16'd0;
      cache_q   <= '0;
      address_q <= '0;
      length_q  <= 9'd0;
      enable_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef PATTERN_GEN_FRAME_REPEAT_EN
      frame_count_q <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      color0_q  <= color0_d;
      color1_q  <= color1_d;
      width_q   <= width_d;
      height_q  <= height_d;
      base_q    <= base_d;
      x_q       <= x_d;
      y_q       <= y_d;
      cache_q   <= cache_d;
      address_q <= address_d;
      length_q  <= length_d;
      enable_q  <= enable_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef PATTERN_GEN_FRAME_REPEAT_EN
      frame_count_q <= frame_count_d;
`endif
    end
  end

  assign o_wire_cache_address = address_q;
  assign o_wire_cache_length  = length_q;
  assign o_wire_cache         = cache_q;
  assign o_wire_writer_enable = enable_q;
  assign o_wire_busy          = busy_q;
  assign o_wire_done          = done_q;
`ifdef PATTERN_GEN_FRAME_REPEAT_EN
  assign o_wire_frame_count   = frame_count_q;
`endif

endmodule

// File: tb/tb_painterengine_gpu_pattern_gen.sv
// Self-checking bench for painterengine_gpu_pattern_gen: directed and random frames against a burst-level model.
`timescale 1ns/1ps
module tb_painterengine_gpu_pattern_gen;

  localparam int AW = 32;
  localparam int CM = 64;
  localparam int S  = 3;

  logic            clk = 1'b0;
  logic            resetn;
  logic            start;
  logic [1:0]      mode;
  logic [31:0]     color0, color1;
  logic [15:0]     width, height;
  logic [AW-1:0]   base;
  logic [AW-1:0]   addr;
  logic [8:0]      len;
  logic [32*CM-1:0] cache;
  logic            en;
  logic            writer_done;
  logic            busy;
  logic            done;
`ifdef PATTERN_GEN_FRAME_REPEAT_EN
  logic [15:0]     frame_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  painterengine_gpu_pattern_gen #(
    .PARAM_ADDRESS_WIDTH (AW),
    .PARAM_CACHE_MAX_SIZE(CM),
    .PARAM_CHECKER_SHIFT (S)
  ) dut (
    .i_wire_axi_clock     (clk),
    .i_wire_resetn        (resetn),
    .i_wire_start         (start),
    .i_wire_mode          (mode),
    .i_wire_color0        (color0),
    .i_wire_color1        (color1),
    .i_wire_display_width (width),
    .i_wire_display_height(height),
    .i_wire_base_address  (base),
    .o_wire_cache_address (addr),
    .o_wire_cache_length  (len),
    .o_wire_cache         (cache),
    .o_wire_writer_enable (en),
    .i_wire_writer_done   (writer_done),
    .o_wire_busy          (busy),
    .o_wire_done          (done)
`ifdef PATTERN_GEN_FRAME_REPEAT_EN
    ,
    .o_wire_frame_count   (frame_count)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nonzero_words(input logic [32*CM-1:0] c);
    int n = 0;
    for (int j = 0; j < CM; j++) if (c[j*32 +: 32] !== 32'h0) n++;
    return n;
  endfunction

  // Reference pixel rule evaluated directly from the pattern definitions.
  function automatic logic [31:0] pix(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                                      input int px, input int py);
    logic [7:0] xb;
    logic [7:0] yb;
    xb = 8'(px % 256);
    yb = 8'(py % 256);
    case (m)
      2'd0:    return a;
      2'd1:    return ((((px >> S) ^ (py >> S)) & 1) != 0) ? b : a;
      2'd2:    return {8'hFF, xb, xb, xb};
      default: return {8'hFF, yb, yb, yb};
    endcase
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, " enable"}, 64'(en), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " address"}, 64'(addr), 64'd0);
    chk({tag, " length"}, 64'(len), 64'd0);
    chk({tag, " cache words"}, 64'(nonzero_words(cache)), 64'd0);
  endtask

  // Runs one frame with a writer that acknowledges dly cycles after each request appears.
  task automatic run_frame(input string tag, input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                           input int fw, input int fh, input logic [31:0] fb, input int dly, input bit scramble);
    int mx, my, nb_exp, nb_seen, idx, low_run, wait_cnt, done_idx, budget, bad, cur_len;
    bit active, prev_en, finished, last;
    logic [31:0] cur_addr;
    logic [31:0] cur_pix [CM];
    mx = 0; my = 0; nb_seen = 0; idx = 0; low_run = 0; wait_cnt = 0; done_idx = -1;
    active = 0; prev_en = 0; finished = 0; last = 0; cur_len = 0; cur_addr = 32'h0;
    for (int j = 0; j < CM; j++) cur_pix[j] = 32'h0;
    nb_exp = fh * ((fw + CM - 1) / CM);
    budget = nb_exp * (dly + 4) + 20;

    @(negedge clk);
    mode = m; color0 = a; color1 = b; width = 16'(fw); height = 16'(fh); base = fb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy after start"}, 64'(busy), 64'd1);

    while (!finished && idx < budget) begin
      writer_done = 1'b0;
      if (scramble) begin
        mode = 2'($urandom); color0 = $urandom; color1 = $urandom;
        width = 16'($urandom); height = 16'($urandom); base = $urandom;
      end
      if (en && !prev_en) begin
        if (nb_seen == 0) chk({tag, " first request cycle"}, 64'(idx), 64'd2);
        else              chk({tag, " request gap"}, 64'(low_run), 64'd1);
        cur_len  = (fw - mx < CM) ? fw - mx : CM;
        cur_addr = fb + 32'((my * fw + mx) * 4);
        for (int j = 0; j < CM; j++) cur_pix[j] = (j < cur_len) ? pix(m, a, b, mx + j, my) : 32'h0;
        last = (my == fh - 1) && (mx + cur_len == fw);
        mx += cur_len;
        if (mx == fw) begin mx = 0; my++; end
        nb_seen++;
        active   = 1'b1;
        wait_cnt = dly;
      end
      if (en) begin
        low_run = 0;
        chk({tag, " address"}, 64'(addr), 64'(cur_addr));
        chk({tag, " length"}, 64'(len), 64'(cur_len));
        bad = 0;
        for (int j = 0; j < CM; j++) if (cache[j*32 +: 32] !== cur_pix[j]) bad++;
        chk({tag, " wrong cache words"}, 64'(bad), 64'd0);
      end else begin
        low_run++;
      end
      chk({tag, " done pulse"}, 64'(done), 64'(done_idx >= 0 && idx == done_idx + 1));
      if (done_idx >= 0 && idx == done_idx + 1) chk({tag, " busy in done"}, 64'(busy), 64'd1);
      if (done_idx >= 0 && idx == done_idx + 2) begin
        chk({tag, " busy after frame"}, 64'(busy), 64'd0);
        finished = 1'b1;
      end
      if (active) begin
        if (wait_cnt == 0) begin
          writer_done = 1'b1;
          active      = 1'b0;
          if (last) done_idx = idx;
        end else begin
          wait_cnt--;
        end
      end
      prev_en = en;
      @(negedge clk);
      idx++;
    end
    writer_done = 1'b0;
    chk({tag, " frame completed in budget"}, 64'(finished), 64'd1);
    chk({tag, " burst count"}, 64'(nb_seen), 64'(nb_exp));
  endtask

  initial begin
    int pulses, en_seen, k, idle_cycles;
    bit prev;
    resetn = 1'b0; start = 1'b0; mode = 2'd0; color0 = 32'h0; color1 = 32'h0;
    width = 16'd0; height = 16'd0; base = 32'h0; writer_done = 1'b0;

    repeat (2) @(negedge clk);
    check_idle("in reset");
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("idle after reset");

    // Writer acknowledge while idle must be ignored.
    writer_done = 1'b1;
    @(negedge clk);
    writer_done = 1'b0;
    chk("stray writer done busy", 64'(busy), 64'd0);
    chk("stray writer done enable", 64'(en), 64'd0);

    // Empty frames: a single done pulse and no request.
    for (int t = 0; t < 2; t++) begin
      width = (t == 0) ? 16'd0 : 16'd10;
      height = (t == 0) ? 16'd5 : 16'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      pulses = 0; en_seen = 0;
      for (int i = 0; i < 4; i++) begin
        if (done) pulses++;
        if (en) en_seen++;
        @(negedge clk);
      end
      chk("empty frame done pulses", 64'(pulses), 64'd1);
      chk("empty frame requests", 64'(en_seen), 64'd0);
      chk("empty frame busy at end", 64'(busy), 64'd0);
    end

    run_frame("solid 16x2", 2'd0, 32'hDEADBEEF, 32'h12345678, 16, 2, 32'h1000, 0, 1'b0);
    run_frame("xgrad 150x1", 2'd2, 32'h0, 32'h0, 150, 1, 32'h2000, 0, 1'b0);
    run_frame("checker 16x9", 2'd1, 32'hFF00FFFF, 32'hFFFF00FF, 16, 9, 32'h0, 0, 1'b0);
    run_frame("ygrad slow scrambled", 2'd3, 32'h0, 32'h0, 70, 3, 32'h8000, 10, 1'b1);
    run_frame("checker slow scrambled", 2'd1, 32'hAAAA5555, 32'h0F0F0F0F, 40, 2, 32'h400, 10, 1'b1);
    run_frame("width 64", 2'd2, 32'h0, 32'h0, 64, 2, 32'h100, 1, 1'b0);
    run_frame("width 65", 2'd2, 32'h0, 32'h0, 65, 1, 32'h100, 0, 1'b0);
    run_frame("address wrap", 2'd0, 32'h11223344, 32'h0, 20, 2, 32'hFFFF_FFC0, 0, 1'b0);

    for (int r = 0; r < 5; r++) begin
      run_frame("random", 2'($urandom_range(0, 3)), $urandom, $urandom,
                int'($urandom_range(1, 200)), int'($urandom_range(1, 3)), $urandom,
                int'($urandom_range(0, 3)), 1'b1);
    end

    // Reset in the middle of a burst request.
    @(negedge clk);
    mode = 2'd2; width = 16'd200; height = 16'd1; base = 32'h40; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!en && k < 10) begin @(negedge clk); k++; end
    chk("request before reset", 64'(en), 64'd1);
    #2 resetn = 1'b0;
    #1 check_idle("async reset mid burst");
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("abandoned frame busy", 64'(busy), 64'd0);

`ifdef PATTERN_GEN_FRAME_REPEAT_EN
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("frame count after reset", 64'(frame_count), 64'd0);
    mode = 2'd1; width = 16'd4; height = 16'd2; start = 1'b1;
    pulses = 0; idle_cycles = 0; k = 0; prev = 1'b0;
    while (pulses < 3 && k < 300) begin
      writer_done = 1'b0;
      if (k > 0 && !busy) idle_cycles++;
      if (en && !prev) writer_done = 1'b1;
      if (done) begin
        pulses++;
        chk("frame count at done", 64'(frame_count), 64'(pulses));
        if (pulses == 3) start = 1'b0;
      end
      prev = en;
      @(negedge clk);
      k++;
    end
    writer_done = 1'b0;
    chk("repeat frames done", 64'(pulses), 64'd3);
    chk("repeat idle cycles", 64'(idle_cycles), 64'd0);
    chk("repeat busy after stop", 64'(busy), 64'd0);
    chk("repeat final count", 64'(frame_count), 64'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
